// File: rtl/regdst_write_seq.sv
// Register-file write-port sequencer: per instruction class it drives the RegDst and
// write-data selects and times the RegWrite strobe, including load waits and pop's double write.
module regdst_write_seq #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          SP_ENABLE   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op_class,
    input  logic [4:0] rd_idx,
    input  logic [4:0] rt_idx,
    input  logic       mem_ready,
    output logic [2:0] reg_dst,
    output logic [1:0] wdata_sel,
    output logic       reg_write,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitMem,
        StWrite1,
        StWrite2,
        StFinish
    } state_t;

    localparam logic [2:0] CLS_RTYPE   = 3'd0;
    localparam logic [2:0] CLS_IALU    = 3'd1;
    localparam logic [2:0] CLS_LOAD    = 3'd2;
    localparam logic [2:0] CLS_JAL     = 3'd3;
    localparam logic [2:0] CLS_PUSH    = 3'd4;
    localparam logic [2:0] CLS_POP     = 3'd5;
    localparam logic [2:0] CLS_NOWRITE = 3'd6;
    localparam logic [2:0] CLS_RSV     = 3'd7;

    localparam logic [2:0] DST_RA = 3'b000;
    localparam logic [2:0] DST_SP = 3'b001;
    localparam logic [2:0] DST_RD = 3'b010;
    localparam logic [2:0] DST_RT = 3'b011;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;
    localparam logic [1:0] SEL_SP  = 2'b11;

    // Last wait cycle index; the counter starts at 0 on the first WAIT_MEM cycle.
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [2:0] cls_q;
    logic [4:0] rd_q;
    logic [4:0] rt_q;
    logic       rsv_q;
    logic [7:0] cnt;

    // First-write destination and data source, packed as {reg_dst, wdata_sel}.
    function automatic logic [4:0] write_path(input logic [2:0] cls);
        logic [4:0] path;
        path = {DST_RA, SEL_ALU};
        case (cls)
            CLS_RTYPE: path = {DST_RD, SEL_ALU};
            CLS_IALU:  path = {DST_RT, SEL_ALU};
            CLS_LOAD:  path = {DST_RT, SEL_MEM};
            CLS_JAL:   path = {DST_RA, SEL_PC4};
            CLS_PUSH:  path = {DST_SP, SEL_SP};
            CLS_POP:   path = {DST_RT, SEL_MEM};
            default:   path = {DST_RA, SEL_ALU};
        endcase
        return path;
    endfunction

    // Writes aimed at register 0 through rd/rt are dropped; $31/$29 always go through.
    function automatic logic write_allowed(input logic [2:0] dst, input logic [4:0] rd,
                                           input logic [4:0] rt);
        logic ok;
        ok = 1'b1;
        if (dst == DST_RD && rd == 5'd0) ok = 1'b0;
        if (dst == DST_RT && rt == 5'd0) ok = 1'b0;
        return ok;
    endfunction

    logic       rsv_in;
    logic       mem_in;
    logic       write_in;
    logic [4:0] path_in;
    logic [4:0] path_q;

    assign rsv_in   = (op_class == CLS_RSV) ||
                      (!SP_ENABLE && (op_class == CLS_PUSH || op_class == CLS_POP));
    assign mem_in   = !rsv_in && (op_class == CLS_LOAD || op_class == CLS_POP);
    assign write_in = !rsv_in && (op_class != CLS_NOWRITE);
    assign path_in  = write_path(op_class);
    assign path_q   = write_path(cls_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cls_q     <= '0;
            rd_q      <= '0;
            rt_q      <= '0;
            rsv_q     <= 1'b0;
            cnt       <= '0;
            reg_dst   <= '0;
            wdata_sel <= '0;
            reg_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        cls_q <= op_class;
                        rd_q  <= rd_idx;
                        rt_q  <= rt_idx;
                        rsv_q <= rsv_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        if (mem_in) begin
                            state <= StWaitMem;
                        end else begin
                            // Non-writing classes still spend the write slot, idle.
                            state <= StWrite1;
                            if (write_in) begin
                                reg_dst   <= path_in[4:2];
                                wdata_sel <= path_in[1:0];
                                reg_write <= write_allowed(path_in[4:2], rd_idx, rt_idx);
                            end
                        end
                    end
                end
                StWaitMem: begin
                    if (mem_ready) begin
                        state     <= StWrite1;
                        reg_dst   <= path_q[4:2];
                        wdata_sel <= path_q[1:0];
                        reg_write <= write_allowed(path_q[4:2], rd_q, rt_q);
                    end else if (cnt == CNT_LAST) begin
                        state <= StFinish;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StWrite1: begin
                    if (cls_q == CLS_POP && !rsv_q) begin
                        state     <= StWrite2;
                        reg_dst   <= DST_SP;
                        wdata_sel <= SEL_SP;
                        reg_write <= 1'b1;
                    end else begin
                        state <= StFinish;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= rsv_q;
                    end
                end
                StWrite2: begin
                    state <= StFinish;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                StFinish: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regdst_write_seq.sv
// Self-checking bench for regdst_write_seq: per-transaction schedule model plus
// directed literal checks from the test plan and randomized traffic.
module tb_regdst_write_seq;

    localparam int unsigned T  = 15;
    localparam bit          SP = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op_class;
    logic [4:0] rd_idx;
    logic [4:0] rt_idx;
    logic       mem_ready;
    logic [2:0] reg_dst;
    logic [1:0] wdata_sel;
    logic       reg_write;
    logic       busy;
    logic       done;
    logic       err;

    regdst_write_seq #(
        .MEM_TIMEOUT(T),
        .SP_ENABLE  (SP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_class (op_class),
        .rd_idx   (rd_idx),
        .rt_idx   (rt_idx),
        .mem_ready(mem_ready),
        .reg_dst  (reg_dst),
        .wdata_sel(wdata_sel),
        .reg_write(reg_write),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle, and model state that persists across cycles.
    logic       e_rw, e_busy, e_done, e_err;
    logic [2:0] e_dst;
    logic [1:0] e_sel;
    logic       m_err;
    logic [2:0] m_dst;
    logic [1:0] m_sel;

    logic       obs_rw  [64];
    logic [2:0] obs_dst [64];
    logic [1:0] obs_sel [64];
    logic       obs_done[64];
    logic       obs_err [64];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("reg_write", 8'(reg_write), 8'(e_rw));
            chk("reg_dst",   8'(reg_dst),   8'(e_dst));
            chk("wdata_sel", 8'(wdata_sel), 8'(e_sel));
            chk("busy",      8'(busy),      8'(e_busy));
            chk("done",      8'(done),      8'(e_done));
            chk("err",       8'(err),       8'(e_err));
        end
    end

    task automatic set_idle_exp();
        e_rw   = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_dst  = m_dst;
        e_sel  = m_sel;
        e_err  = m_err;
    endtask

    task automatic record(input int c);
        obs_rw[c]   = reg_write;
        obs_dst[c]  = reg_dst;
        obs_sel[c]  = wdata_sel;
        obs_done[c] = done;
        obs_err[c]  = err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            op_class  = 3'($urandom);
            rd_idx    = 5'($urandom);
            rt_idx    = 5'($urandom);
            mem_ready = 1'($urandom);
            set_idle_exp();
        end
    endtask

    // One instruction: k is the mem_ready cycle (0 = never); noise adds ignored
    // starts during busy/done and stray mem_ready outside the wait window.
    task automatic run_txn(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rt,
                           input int k, input bit noise, output int done_c);
        bit         rsv, mem, pop, tmo;
        int         nw, first, w;
        logic [2:0] d[2];
        logic [1:0] s[2];
        logic       en[2];

        rsv = (op == 3'd7) || (!SP && (op == 3'd4 || op == 3'd5));
        mem = !rsv && (op == 3'd2 || op == 3'd5);
        pop = !rsv && (op == 3'd5);
        nw  = (rsv || op == 3'd6) ? 0 : (pop ? 2 : 1);
        case (op)
            3'd0:    begin d[0] = 3'b010; s[0] = 2'b00; end
            3'd1:    begin d[0] = 3'b011; s[0] = 2'b00; end
            3'd2:    begin d[0] = 3'b011; s[0] = 2'b01; end
            3'd3:    begin d[0] = 3'b000; s[0] = 2'b10; end
            3'd4:    begin d[0] = 3'b001; s[0] = 2'b11; end
            3'd5:    begin d[0] = 3'b011; s[0] = 2'b01; end
            default: begin d[0] = 3'b000; s[0] = 2'b00; end
        endcase
        en[0] = !((d[0] == 3'b010 && rd == 5'd0) || (d[0] == 3'b011 && rt == 5'd0));
        d[1]  = 3'b001;
        s[1]  = 2'b11;
        en[1] = 1'b1;
        tmo   = mem && (k == 0);
        first = 0;
        if (tmo) begin
            nw     = 0;
            done_c = int'(T) + 1;
        end else if (mem) begin
            first  = k + 1;
            done_c = first + nw;
        end else begin
            first  = 1;
            done_c = (nw == 0) ? 2 : 1 + nw;
        end
        for (int i = 0; i < 64; i++) begin
            obs_rw[i]   = 1'b0;
            obs_done[i] = 1'b0;
        end

        @(posedge clk);
        #1;
        start     = 1'b1;
        op_class  = op;
        rd_idx    = rd;
        rt_idx    = rt;
        mem_ready = noise ? 1'($urandom) : 1'b0;
        set_idle_exp();
        #1;
        record(0);

        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk);
            #1;
            start    = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            op_class = 3'($urandom);
            rd_idx   = 5'($urandom);
            rt_idx   = 5'($urandom);
            if (mem && (tmo ? c <= int'(T) : c <= k)) mem_ready = (c == k);
            else mem_ready = noise ? 1'($urandom) : 1'b0;
            w    = c - first;
            e_rw = 1'b0;
            if (nw > 0 && c >= first && w < nw) begin
                e_rw  = en[w];
                m_dst = d[w];
                m_sel = s[w];
            end
            if (c == 1) m_err = 1'b0;
            if (c == done_c) m_err = rsv || tmo;
            e_dst  = m_dst;
            e_sel  = m_sel;
            e_err  = m_err;
            e_busy = (c < done_c);
            e_done = (c == done_c);
            #1;
            record(c);
        end
    endtask

    int dc;

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        op_class  = '0;
        rd_idx    = '0;
        rt_idx    = '0;
        mem_ready = 1'b0;
        m_dst     = '0;
        m_sel     = '0;
        m_err     = 1'b0;
        set_idle_exp();
        #3;
        chk("reset_reg_write", 8'(reg_write), 8'd0);
        chk("reset_reg_dst",   8'(reg_dst),   8'd0);
        chk("reset_wdata_sel", 8'(wdata_sel), 8'd0);
        chk("reset_busy",      8'(busy),      8'd0);
        chk("reset_done",      8'(done),      8'd0);
        chk("reset_err",       8'(err),       8'd0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // R-type to rd=5, then to rd=0 (suppressed write, same timing).
        run_txn(3'd0, 5'd5, 5'd7, 0, 1'b0, dc);
        chk("rtype_c1_write", 8'(obs_rw[1]),   8'd1);
        chk("rtype_c1_dst",   8'(obs_dst[1]),  8'b010);
        chk("rtype_c1_sel",   8'(obs_sel[1]),  8'b00);
        chk("rtype_c2_done",  8'(obs_done[2]), 8'd1);
        chk("rtype_c2_write", 8'(obs_rw[2]),   8'd0);
        idle(1);
        run_txn(3'd0, 5'd0, 5'd7, 0, 1'b0, dc);
        chk("rzero_c1_write", 8'(obs_rw[1]),   8'd0);
        chk("rzero_c1_dst",   8'(obs_dst[1]),  8'b010);
        chk("rzero_c2_done",  8'(obs_done[2]), 8'd1);
        idle(1);

        // Load with mem_ready in cycle 4.
        run_txn(3'd2, 5'd3, 5'd9, 4, 1'b0, dc);
        chk("load_c4_write", 8'(obs_rw[4]),   8'd0);
        chk("load_c5_write", 8'(obs_rw[5]),   8'd1);
        chk("load_c5_dst",   8'(obs_dst[5]),  8'b011);
        chk("load_c5_sel",   8'(obs_sel[5]),  8'b01);
        chk("load_c6_done",  8'(obs_done[6]), 8'd1);
        idle(1);

        // Pop, rt=8, mem_ready in cycle 2, with starts thrown at it while busy.
        run_txn(3'd5, 5'd0, 5'd8, 2, 1'b1, dc);
        chk("pop_c3_write", 8'(obs_rw[3]),   8'd1);
        chk("pop_c3_dst",   8'(obs_dst[3]),  8'b011);
        chk("pop_c3_sel",   8'(obs_sel[3]),  8'b01);
        chk("pop_c4_write", 8'(obs_rw[4]),   8'd1);
        chk("pop_c4_dst",   8'(obs_dst[4]),  8'b001);
        chk("pop_c4_sel",   8'(obs_sel[4]),  8'b11);
        chk("pop_c5_done",  8'(obs_done[5]), 8'd1);
        idle(1);

        // Load timeout, then jal clears err.
        run_txn(3'd2, 5'd3, 5'd9, 0, 1'b0, dc);
        chk("tmo_c15_done", 8'(obs_done[15]), 8'd0);
        chk("tmo_c16_done", 8'(obs_done[16]), 8'd1);
        chk("tmo_c16_err",  8'(obs_err[16]),  8'd1);
        idle(2);
        run_txn(3'd3, 5'd0, 5'd0, 0, 1'b0, dc);
        chk("jal_c0_err",   8'(obs_err[0]),  8'd1);
        chk("jal_c1_err",   8'(obs_err[1]),  8'd0);
        chk("jal_c1_write", 8'(obs_rw[1]),   8'd1);
        chk("jal_c1_dst",   8'(obs_dst[1]),  8'b000);
        chk("jal_c1_sel",   8'(obs_sel[1]),  8'b10);
        idle(1);

        // Reserved and no-write classes.
        run_txn(3'd7, 5'd4, 5'd4, 0, 1'b0, dc);
        chk("rsv_c1_write", 8'(obs_rw[1]),   8'd0);
        chk("rsv_c2_done",  8'(obs_done[2]), 8'd1);
        chk("rsv_c2_err",   8'(obs_err[2]),  8'd1);
        idle(1);
        run_txn(3'd6, 5'd4, 5'd4, 0, 1'b0, dc);
        chk("nw_c1_write", 8'(obs_rw[1]),   8'd0);
        chk("nw_c2_done",  8'(obs_done[2]), 8'd1);
        chk("nw_c2_err",   8'(obs_err[2]),  8'd0);
        idle(1);

        // Asynchronous reset in the middle of a load's memory wait.
        @(posedge clk);
        #1;
        start     = 1'b1;
        op_class  = 3'd2;
        rd_idx    = 5'd1;
        rt_idx    = 5'd9;
        mem_ready = 1'b0;
        set_idle_exp();
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            start  = 1'b0;
            m_err  = 1'b0;
            set_idle_exp();
            e_busy = 1'b1;
        end
        #2;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_mid_write", 8'(reg_write), 8'd0);
        chk("rst_mid_dst",   8'(reg_dst),   8'd0);
        chk("rst_mid_sel",   8'(wdata_sel), 8'd0);
        chk("rst_mid_busy",  8'(busy),      8'd0);
        chk("rst_mid_done",  8'(done),      8'd0);
        chk("rst_mid_err",   8'(err),       8'd0);
        @(posedge clk);
        #3;
        reset  = 1'b1;
        m_dst  = '0;
        m_sel  = '0;
        m_err  = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        idle(5);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [2:0] op;
            logic [4:0] rd, rt;
            int         k;
            op = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            k  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, T);
            run_txn(op, rd, rt, k, 1'($urandom), dc);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
